// File: rtl/button_event_decoder.sv
// button_event_decoder
//
// Classifies debounced key actions as short press, double press or long press.
// The debounced level changes on a divided clock edge, so it is resynchronised
// to CLOCK. The resynchronised level is normalised so that 1 always means
// "pressed".
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   defined   -> REPEATP pulses every RPT_CYC cycles while in the long-hold state
//   undefined -> no repeat timer; REPEATP tied to 0
//
// Ports
//   CLOCK    in   main clock, all logic on posedge
//   NRESET   in   asynchronous active-low reset
//   SWITCHI  in   debounced key level
//   PRESSED  out  synchronised, polarity-normalised key level (1 = pressed)
//   SHORTP   out  1-cycle pulse: single short press completed
//   DOUBLEP  out  1-cycle pulse: double press completed
//   LONGP    out  1-cycle pulse: press reached LONG_CYC
//   HOLD     out  high while in the long-hold state
//   REPEATP  out  1-cycle auto-repeat pulse while held
module button_event_decoder #(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned LONG_CYC   = 25_000_000,
  parameter int unsigned DBL_CYC    = 12_500_000,
  parameter int unsigned RPT_CYC    = 5_000_000
) (
  input  logic CLOCK,
  input  logic NRESET,
  input  logic SWITCHI,
  output logic PRESSED,
  output logic SHORTP,
  output logic DOUBLEP,
  output logic LONGP,
  output logic HOLD,
  output logic REPEATP
);

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DblLast  = CNT_W'(DBL_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StGap,
    StPress2,
    StLong
  } state_e;

  state_e           state_q;
  logic             sync_q;
  logic [CNT_W-1:0] timer_q;

  // Sync chain, classification FSM and registered event outputs.
  // The sync chain resets to the normalised released level (0).
  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      sync_q  <= 1'b0;
      PRESSED <= 1'b0;
      state_q <= StIdle;
      timer_q <= '0;
      SHORTP  <= 1'b0;
      DOUBLEP <= 1'b0;
      LONGP   <= 1'b0;
      HOLD    <= 1'b0;
    end else begin
      sync_q  <= SWITCHI ^ ACTIVE_LOW;
      PRESSED <= sync_q;

      SHORTP  <= 1'b0;
      DOUBLEP <= 1'b0;
      LONGP   <= 1'b0;

      // Saturating count; any state change below overrides with a clear.
      timer_q <= (&timer_q) ? timer_q : timer_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (PRESSED) begin
            state_q <= StPress1;
            timer_q <= '0;
          end
        end
        StPress1: begin
          // Timeout is checked before release so a same-cycle release still
          // classifies as a long press.
          if (timer_q == LongLast) begin
            state_q <= StLong;
            timer_q <= '0;
            LONGP   <= 1'b1;
            HOLD    <= 1'b1;
          end else if (!PRESSED) begin
            state_q <= StGap;
            timer_q <= '0;
          end
        end
        StGap: begin
          // A press arriving on the timeout cycle still forms a double press.
          if (PRESSED) begin
            state_q <= StPress2;
            timer_q <= '0;
          end else if (timer_q == DblLast) begin
            state_q <= StIdle;
            timer_q <= '0;
            SHORTP  <= 1'b1;
          end
        end
        StPress2: begin
          if (!PRESSED) begin
            state_q <= StIdle;
            timer_q <= '0;
            DOUBLEP <= 1'b1;
          end
        end
        StLong: begin
          if (!PRESSED) begin
            state_q <= StIdle;
            timer_q <= '0;
            HOLD    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          timer_q <= '0;
          HOLD    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RptLast = CNT_W'(RPT_CYC - 1);

  logic [CNT_W-1:0] rpt_q;

  // Held at 0 outside the long-hold state, so it starts from 0 on entry and
  // a release stops the repeat on the very cycle it is seen.
  always_ff @(posedge CLOCK or negedge NRESET) begin
    if (!NRESET) begin
      rpt_q   <= '0;
      REPEATP <= 1'b0;
    end else begin
      REPEATP <= 1'b0;
      if (state_q == StLong && PRESSED) begin
        if (rpt_q == RptLast) begin
          rpt_q   <= '0;
          REPEATP <= 1'b1;
        end else begin
          rpt_q <= rpt_q + 1'b1;
        end
      end else begin
        rpt_q <= '0;
      end
    end
  end
`else
  assign REPEATP = 1'b0;

  // RPT_CYC has no effect without auto-repeat; referenced here only so the
  // parameter is not reported as unused.
  if (RPT_CYC == 0) begin : g_rpt_unused
  end
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder. Two instances (ACTIVE_LOW=1 and ACTIVE_LOW=0)
// receive the same logical key stream with opposite electrical polarity, so
// one reference model serves both.
module tb_button_event_decoder;

  localparam int unsigned LongCyc = 20;
  localparam int unsigned DblCyc  = 10;
  localparam int unsigned RptCyc  = 5;
  localparam int unsigned CntW    = 8;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit RptOn = 1'b1;
`else
  localparam bit RptOn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sw_h  = 1'b1;
  logic sw_l  = 1'b0;

  logic pr_h, sh_h, db_h, lg_h, hd_h, rp_h;
  logic pr_l, sh_l, db_l, lg_l, hd_l, rp_l;

  button_event_decoder #(
    .ACTIVE_LOW(1'b1), .CNT_W(CntW), .LONG_CYC(LongCyc), .DBL_CYC(DblCyc), .RPT_CYC(RptCyc)
  ) dut_h (
    .CLOCK(clk), .NRESET(rst_n), .SWITCHI(sw_h), .PRESSED(pr_h), .SHORTP(sh_h),
    .DOUBLEP(db_h), .LONGP(lg_h), .HOLD(hd_h), .REPEATP(rp_h)
  );

  button_event_decoder #(
    .ACTIVE_LOW(1'b0), .CNT_W(CntW), .LONG_CYC(LongCyc), .DBL_CYC(DblCyc), .RPT_CYC(RptCyc)
  ) dut_l (
    .CLOCK(clk), .NRESET(rst_n), .SWITCHI(sw_l), .PRESSED(pr_l), .SHORTP(sh_l),
    .DOUBLEP(db_l), .LONGP(lg_l), .HOLD(hd_l), .REPEATP(rp_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int n_short, n_double, n_long;

  // Reference model, described per key action: the level the classifier sees
  // lags the key by two clocks; a press counts its age, a release counts its
  // gap, and the action ends with at most one classification.
  bit m_lag1, m_lag2;
  bit m_busy, m_second, m_in_gap, m_long;
  int m_age, m_rpt;
  bit e_pressed, e_short, e_double, e_long, e_hold, e_rpt;

  task automatic model_reset();
    m_lag1 = 0; m_lag2 = 0;
    m_busy = 0; m_second = 0; m_in_gap = 0; m_long = 0;
    m_age = 0; m_rpt = 0;
    e_pressed = 0; e_short = 0; e_double = 0; e_long = 0; e_hold = 0; e_rpt = 0;
  endtask

  task automatic model_edge(input bit press);
    bit seen;
    seen   = m_lag2;
    m_lag2 = m_lag1;
    m_lag1 = press;
    e_short = 0; e_double = 0; e_long = 0; e_rpt = 0;
    if (!m_busy) begin
      if (seen) begin
        m_busy = 1; m_second = 0; m_in_gap = 0; m_long = 0; m_age = 0;
      end
    end else if (m_long) begin
      if (!seen) m_busy = 0;
      else if (RptOn) begin
        if (m_rpt == RptCyc - 1) begin e_rpt = 1; m_rpt = 0; end
        else m_rpt++;
      end
    end else if (m_second) begin
      if (!seen) begin m_busy = 0; e_double = 1; end
    end else if (m_in_gap) begin
      if (seen) begin m_second = 1; m_in_gap = 0; end
      else if (m_age == DblCyc - 1) begin m_busy = 0; e_short = 1; end
      else m_age++;
    end else begin
      if (m_age == LongCyc - 1) begin m_long = 1; e_long = 1; m_rpt = 0; end
      else if (!seen) begin m_in_gap = 1; m_age = 0; end
      else m_age++;
    end
    e_pressed = m_lag2;
    e_hold    = m_busy && m_long;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
  endtask

  task automatic chk_cnt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
  endtask

  task automatic compare_all();
    chk("pressed_h", pr_h, e_pressed); chk("pressed_l", pr_l, e_pressed);
    chk("shortp_h",  sh_h, e_short);   chk("shortp_l",  sh_l, e_short);
    chk("doublep_h", db_h, e_double);  chk("doublep_l", db_l, e_double);
    chk("longp_h",   lg_h, e_long);    chk("longp_l",   lg_l, e_long);
    chk("hold_h",    hd_h, e_hold);    chk("hold_l",    hd_l, e_hold);
    chk("repeatp_h", rp_h, e_rpt);     chk("repeatp_l", rp_l, e_rpt);
    if (sh_h === 1'b1) n_short++;
    if (db_h === 1'b1) n_double++;
    if (lg_h === 1'b1) n_long++;
  endtask

  task automatic clear_counts();
    n_short = 0; n_double = 0; n_long = 0;
  endtask

  // One clock with the key held at the given logical level.
  task automatic step(input bit press);
    sw_h = ~press;
    sw_l = press;
    @(posedge clk);
    if (rst_n) model_edge(press);
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic hold_key(input bit press, input int n);
    for (int i = 0; i < n; i++) step(press);
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    hold_key(0, 2);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_counts();
    #2;
    compare_all();
    hold_key(0, 2);
    rst_n = 1'b1;
    hold_key(0, 3);

    // Short press: SHORTP after the gap timeout, nothing else.
    clear_counts();
    hold_key(1, 5); hold_key(0, 25);
    chk_cnt("s1_short", n_short, 1); chk_cnt("s1_double", n_double, 0);
    chk_cnt("s1_long", n_long, 0);

    // Double press.
    clear_counts();
    hold_key(1, 5); hold_key(0, 4); hold_key(1, 5); hold_key(0, 25);
    chk_cnt("s2_double", n_double, 1); chk_cnt("s2_short", n_short, 0);

    // Long press with hold and optional repeat.
    clear_counts();
    hold_key(1, 40); hold_key(0, 25);
    chk_cnt("s3_long", n_long, 1); chk_cnt("s3_short", n_short, 0);

    // Second press lands on the gap timeout cycle: press wins.
    clear_counts();
    hold_key(1, 5); hold_key(0, 10); hold_key(1, 5); hold_key(0, 25);
    chk_cnt("s4_gap10_double", n_double, 1); chk_cnt("s4_gap10_short", n_short, 0);

    // One cycle later the gap times out first.
    clear_counts();
    hold_key(1, 5); hold_key(0, 11); hold_key(1, 5); hold_key(0, 25);
    chk_cnt("s4_gap11_short", n_short, 2); chk_cnt("s4_gap11_double", n_double, 0);

    // Release on the long-timeout cycle: timeout wins.
    clear_counts();
    hold_key(1, 20); hold_key(0, 25);
    chk_cnt("s4_rel19_long", n_long, 1); chk_cnt("s4_rel19_short", n_short, 0);

    // One cycle shorter stays a short press.
    clear_counts();
    hold_key(1, 19); hold_key(0, 25);
    chk_cnt("s4_rel18_short", n_short, 1); chk_cnt("s4_rel18_long", n_long, 0);

    // Reset mid-gap and mid-long: the event is dropped silently.
    clear_counts();
    hold_key(1, 5); hold_key(0, 4);
    pulse_reset();
    hold_key(0, 25);
    hold_key(1, 30);
    pulse_reset();
    hold_key(0, 25);
    chk_cnt("s5_short", n_short, 0); chk_cnt("s5_double", n_double, 0);
    chk_cnt("s5_long", n_long, 1);

    // Random key actions around the classification boundaries.
    for (int a = 0; a < 60; a++) begin
      hold_key(1, int'($urandom_range(1, 45)));
      if ($urandom_range(0, 3) == 0) hold_key(0, int'($urandom_range(15, 30)));
      else hold_key(0, int'($urandom_range(1, 14)));
      if ($urandom_range(0, 19) == 0) pulse_reset();
    end
    hold_key(0, 30);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
